// File: rtl/fifo_stream.sv
// First-word-fall-through stream FIFO: DEPTH-entry memory plus one output register, valid/ready on both sides.
// Optional synchronous flush port is compiled in with `define FIFO_FLUSH_EN.
module fifo_stream #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  dn_valid,
  input  logic                  dn_ready,
  output logic [DATA_WIDTH-1:0] dn_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
`ifdef FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits for ready, and data/valid hold while valid & ~ready.

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = PW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = PW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic                  up_ready_q;
  logic                  afull_q, aempty_q;
  logic                  push, pop, mem_empty, load;

  always_comb begin
    push        = up_valid & up_ready_q;
    pop         = out_valid_q & dn_ready;
    mem_empty   = (wptr_q == rptr_q);
    // Prefetch the memory head whenever the output slot is free or being vacated.
    load        = ~mem_empty & (~out_valid_q | pop);
    wptr_d      = wptr_q + PW'(push);
    rptr_d      = rptr_q + PW'(load);
    out_valid_d = load | (out_valid_q & ~pop);
    count_d     = count_q + PW'(push) - PW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      up_ready_q  <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end
`ifdef FIFO_FLUSH_EN
    else if (flush) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end
`endif
    else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      up_ready_q  <= (count_d < DEPTH_C);
      afull_q     <= (count_d >= AFULL_C);
      aempty_q    <= (count_d <= AEMPTY_C);
    end
  end

  // Storage and output data carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= up_data;
  end

  always_ff @(posedge clk) begin
    if (load) out_data_q <= mem_q[rptr_q[ADDR_WIDTH-1:0]];
  end

  assign up_ready     = up_ready_q;
  assign dn_valid     = out_valid_q;
  assign dn_data      = out_data_q;
  assign count        = count_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;

endmodule

// File: tb/tb_fifo_stream.sv
// Bench for fifo_stream: directed steps plus random traffic checked against a timestamped word queue.
module tb_fifo_stream;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int AF_T  = DEPTH - 2;
  localparam int AE_T  = 1;

  logic          clk = 1'b0;
  logic          rst_n, up_valid, dn_ready, flush_r;
  logic          up_ready, dn_valid, almost_full, almost_empty;
  logic [DW-1:0] up_data, dn_data;
  logic [AW:0]   count;

  int checks = 0;
  int errors = 0;

  // Reference: words in acceptance order with the edge number each was accepted on.
  // A head word is visible once at least one full edge has passed since acceptance.
  logic [DW-1:0] exp_q[$];
  int            acc_q[$];
  int            edge_n = 0;
  bit            m_ready = 1'b0;
  int            max_cnt;

  always #5 clk = ~clk;

  fifo_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AF_T), .AEMPTY_THRESH(AE_T)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_FLUSH_EN
    , .flush(flush_r)
`endif
  );

  function automatic bit model_valid();
    return (exp_q.size() != 0) && (acc_q[0] <= edge_n - 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit mv;
    int sz;
    mv = model_valid();
    sz = exp_q.size();
    chk("count", 64'(count), 64'(sz));
    chk("up_ready", 64'(up_ready), 64'(m_ready));
    chk("dn_valid", 64'(dn_valid), 64'(mv));
    if (mv) chk("dn_data", 64'(dn_data), 64'(exp_q[0]));
    chk("almost_full", 64'(almost_full), 64'(sz >= AF_T));
    chk("almost_empty", 64'(almost_empty), 64'(sz <= AE_T));
    if (sz > max_cnt) max_cnt = sz;
  endtask

  // One clock edge: predict from the pre-edge state, then check #1 after the edge.
  task automatic step();
    bit push, pop;
    push = up_valid && m_ready;
    pop  = dn_ready && model_valid();
    @(posedge clk);
    edge_n++;
    if (!rst_n) begin
      exp_q.delete(); acc_q.delete(); m_ready = 1'b0;
    end else if (flush_r) begin
      exp_q.delete(); acc_q.delete();
    end else begin
      if (pop) begin void'(exp_q.pop_front()); void'(acc_q.pop_front()); end
      if (push) begin exp_q.push_back(up_data); acc_q.push_back(edge_n); end
      m_ready = (exp_q.size() < DEPTH);
    end
    #1;
    check_outputs();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    up_valid = 1'b0; dn_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin step(); n++; end
    chk("drain_done", 64'(count), 64'd0);
    dn_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; flush_r = 1'b0; up_data = '0;
    max_cnt = 0;
    #1;
    repeat (3) step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dn_valid", 64'(dn_valid), 64'd0);
    chk("rst_up_ready", 64'(up_ready), 64'd0);
    chk("rst_aempty", 64'(almost_empty), 64'd1);
    chk("rst_afull", 64'(almost_full), 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_up_ready", 64'(up_ready), 64'd1);

    // Single word: one bubble, then held while not taken.
    up_valid = 1'b1; up_data = 32'hA5;
    step();
    up_valid = 1'b0;
    chk("a5_count_k", 64'(count), 64'd1);
    chk("a5_bubble", 64'(dn_valid), 64'd0);
    step();
    chk("a5_valid_k1", 64'(dn_valid), 64'd1);
    chk("a5_data_k1", 64'(dn_data), 64'hA5);
    step(); step();
    chk("a5_hold", 64'(dn_data), 64'hA5);
    dn_ready = 1'b1; step(); dn_ready = 1'b0;
    chk("a5_popped", 64'(count), 64'd0);

    // Fill to DEPTH, then a 17th word is refused.
    for (int i = 0; i < DEPTH; i++) begin
      up_valid = 1'b1; up_data = DW'(i);
      step();
      if (i == AF_T - 1) chk("afull_at_14", 64'(almost_full), 64'd1);
      if (i == 1) chk("aempty_off_at_2", 64'(almost_empty), 64'd0);
    end
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_up_ready", 64'(up_ready), 64'd0);
    up_data = 32'h99; step();
    chk("held_back", 64'(count), 64'(DEPTH));
    up_valid = 1'b0;

    // Pop one at full: ready returns on that same edge.
    chk("full_head", 64'(dn_data), 64'd0);
    dn_ready = 1'b1; step(); dn_ready = 1'b0;
    chk("pop_full_ready", 64'(up_ready), 64'd1);
    chk("pop_full_count", 64'(count), 64'(DEPTH - 1));
    chk("next_head", 64'(dn_data), 64'd1);
    drain(40);

    // Streaming with producer drops and an always-ready consumer.
    max_cnt = 0;
    dn_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      up_valid = ($urandom_range(0, 99) >= 20);
      up_data  = $urandom;
      step();
    end
    chk("stream_max_cnt_le2", 64'(max_cnt <= 2), 64'd1);
    drain(10);

    // Consumer stalls: fills up and exercises the full boundary.
    for (int i = 0; i < 400; i++) begin
      up_valid = ($urandom_range(0, 99) < 90);
      dn_ready = ($urandom_range(0, 99) < 35);
      up_data  = $urandom;
      step();
    end
    chk("stall_reached_full", 64'(max_cnt), 64'(DEPTH));
    drain(40);

    // Reset in the middle of traffic discards everything.
    for (int i = 0; i < 6; i++) begin
      up_valid = 1'b1; up_data = $urandom; step();
    end
    up_valid = 1'b0; rst_n = 1'b0;
    step();
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_dn_valid", 64'(dn_valid), 64'd0);
    chk("midrst_up_ready", 64'(up_ready), 64'd0);
    rst_n = 1'b1; step();

`ifdef FIFO_FLUSH_EN
    for (int i = 0; i < 5; i++) begin
      up_valid = 1'b1; up_data = 32'h100 + DW'(i); step();
    end
    up_data = 32'h77; flush_r = 1'b1;
    step();
    flush_r = 1'b0;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_dn_valid", 64'(dn_valid), 64'd0);
    chk("flush_aempty", 64'(almost_empty), 64'd1);
    up_data = 32'h3C; step();
    up_valid = 1'b0; step();
    chk("post_flush_head", 64'(dn_data), 64'h3C);
    drain(10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
